// File: rtl/recursive_logic_stage.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake.
// Stage A registers operands/opcode; the bitwise arrays read stage A; stage B holds the
// selected result plus zero/ones flags and a count of results delivered downstream.
module recursive_logic_stage #(
  parameter  int unsigned S = 2,
  localparam int unsigned W = 1 << S
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_zero,
  output logic         out_ones,
  output logic [15:0]  out_count
);

  logic         r_a_valid;
  logic [2:0]   r_a_op;
  logic [W-1:0] r_a_in1;
  logic [W-1:0] r_a_in2;
  logic         r_b_valid;
  logic [W-1:0] r_b_data;
  logic         r_b_zero;
  logic         r_b_ones;
  logic [15:0]  r_count;

  logic         w_b_adv;
  logic         w_a_adv;
  logic         w_in_fire;
  logic         w_out_fire;

  logic [W-1:0] w_buf;
  logic [W-1:0] w_not;
  logic [W-1:0] w_and;
  logic [W-1:0] w_or;
  logic [W-1:0] w_xor;
  logic [W-1:0] w_xnor;
  logic [W-1:0] w_nand;
  logic [W-1:0] w_nor;
  logic [W-1:0] w_res;
  logic         w_zero;
  logic         w_ones;

  assign w_b_adv    = !r_b_valid || out_ready;
  assign w_a_adv    = r_a_valid && w_b_adv;
  assign in_ready   = !r_a_valid || w_b_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_b_valid && out_ready;

  // Per-bit gate arrays; bit i depends only on bit i of the stage-A operands.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign w_buf[i]  = r_a_in1[i];
    assign w_not[i]  = ~r_a_in1[i];
    assign w_and[i]  = r_a_in1[i] & r_a_in2[i];
    assign w_or[i]   = r_a_in1[i] | r_a_in2[i];
    assign w_xor[i]  = r_a_in1[i] ^ r_a_in2[i];
    assign w_xnor[i] = ~(r_a_in1[i] ^ r_a_in2[i]);
    assign w_nand[i] = ~(r_a_in1[i] & r_a_in2[i]);
    assign w_nor[i]  = ~(r_a_in1[i] | r_a_in2[i]);
  end

  // Opcode-indexed result select and flags ahead of the stage-B register.
  always_comb begin
    w_res = '0;
    unique case (r_a_op)
      3'd0: w_res = w_buf;
      3'd1: w_res = w_not;
      3'd2: w_res = w_and;
      3'd3: w_res = w_or;
      3'd4: w_res = w_xor;
      3'd5: w_res = w_xnor;
      3'd6: w_res = w_nand;
      3'd7: w_res = w_nor;
      default: w_res = '0;
    endcase
    w_zero = (w_res == '0);
    w_ones = &w_res;
  end

  // Stage A: capture operands on accept, empty when its contents move to stage B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_valid <= 1'b0;
      r_a_op    <= '0;
      r_a_in1   <= '0;
      r_a_in2   <= '0;
    end else if (w_in_fire) begin
      r_a_valid <= 1'b1;
      r_a_op    <= in_op;
      r_a_in1   <= in1;
      r_a_in2   <= in2;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end
  end

  // Stage B: load result and flags from stage A, empty when downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_zero  <= 1'b0;
      r_b_ones  <= 1'b0;
    end else if (w_a_adv) begin
      r_b_valid <= 1'b1;
      r_b_data  <= w_res;
      r_b_zero  <= w_zero;
      r_b_ones  <= w_ones;
    end else if (out_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  // Delivered-result counter, wraps modulo 2**16.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_valid = r_b_valid;
  assign out_data  = r_b_data;
  assign out_zero  = r_b_zero;
  assign out_ones  = r_b_ones;
  assign out_count = r_count;

endmodule
